ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, e.g. 0xED set-LEDs plus LED mask, or 0xFF reset.
- Opposite direction of the existing keyboard receive path. Shares the PS2_CLK/PS2_DATA pins through open-drain enables at the top level.
- Implements inhibit, request-to-send, bit shifting on device clock edges, and ACK check, with a watchdog timeout.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_edge_sync.sv | 33 +++
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, command bytes and frame builder.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StSend,
        StAck,
        StWaitIdle
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    localparam int unsigned FRAME_BITS = 10;

    // Bits after the start bit, LSB first: d0..d7, odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and status bundle of the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       timeout_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_ok, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_ok, timeout_err
    );

endinterface

// File: rtl/ps2_edge_sync.sv
// Pin synchronizer with one-cycle falling-edge strobe; flops idle high like the bus.
module ps2_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic level,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign fall  = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift on device falls, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_e            state_q, state_d;
    logic [InhW-1:0]       inh_q, inh_d;
    logic [WdW-1:0]        wd_q, wd_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic                  clk_oe_q, clk_oe_d;
    logic                  data_oe_q, data_oe_d;
    logic                  done_q, done_d;
    logic                  ack_ok_q, ack_ok_d;
    logic                  timeout_q, timeout_d;

    logic clk_lvl, clk_fall, data_lvl, unused_data_fall;
    logic wd_active, wd_expired;

    ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_in (ps2_clk_in),
        .level  (clk_lvl),
        .fall   (clk_fall)
    );

    ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_in (ps2_data_in),
        .level  (data_lvl),
        .fall   (unused_data_fall)
    );

    assign wd_active  = (state_q == StSend) || (state_q == StAck) || (state_q == StWaitIdle);
    assign wd_expired = wd_active && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        inh_d     = inh_q;
        wd_d      = wd_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ack_ok_d  = ack_ok_q;
        timeout_d = timeout_q;

        if (wd_active) begin
            wd_d = wd_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.tx_valid) begin
                    frame_d   = build_frame(bus.tx_data);
                    clk_oe_d  = 1'b1;
                    inh_d     = '0;
                    ack_ok_d  = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (inh_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    state_d   = StRts;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            StRts: begin
                clk_oe_d  = 1'b0;
                bit_idx_d = '0;
                wd_d      = '0;
                state_d   = StSend;
            end
            StSend: begin
                // Device samples on its rising edge, so the next bit goes out right after a fall.
                if (clk_fall) begin
                    data_oe_d = ~frame_q[bit_idx_q];
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'(FRAME_BITS - 1)) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                if (clk_fall) begin
                    ack_ok_d = ~data_lvl;
                    state_d  = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (wd_expired) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            timeout_d = 1'b1;
            ack_ok_d  = 1'b0;
            done_d    = 1'b1;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            inh_q     <= '0;
            wd_q      <= '0;
            frame_q   <= '0;
            bit_idx_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_q     <= inh_d;
            wd_q      <= wd_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ack_ok_q  <= ack_ok_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.tx_ready    = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.ack_ok      = ack_ok_q;
    assign bus.timeout_err = timeout_q;
    assign ps2_clk_oe      = clk_oe_q;
    assign ps2_data_oe     = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model, vector table and done-driven scoreboard.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 200;
    localparam int unsigned TMO  = 3000;
    localparam int          HALF = 20;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         dev_ack;
        bit         exp_ack;
    } vec_t;

    typedef struct {
        logic [9:0] frame;
        logic       ack;
        logic       to;
        bit         chk_frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic [9:0] dev_bits = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    exp_t exp_q[$];
    vec_t vecs[6];

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Open-drain wiring: either side can pull a line low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {31'b0, bus.done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_ok", {31'b0, bus.ack_ok}, {31'b0, e.ack});
                chk("timeout_err", {31'b0, bus.timeout_err}, {31'b0, e.to});
                if (e.chk_frame) chk("frame_bits", {22'b0, dev_bits}, {22'b0, e.frame});
            end
        end
    end

    // Device: wait for request-to-send, then clock nclk bits, ACKing on the 11th if asked.
    task automatic run_device(input bit do_ack, input int nclk);
        int w = 0;
        dev_bits = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < int'(INH) + 50) begin
            @(negedge clk);
            w++;
        end
        chk("rts_seen", {31'b0, (ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1)}, 32'd1);
        repeat (5) @(negedge clk);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && do_ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 10) dev_bits[k-1] = ps2_data_in;
            repeat (HALF) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic issue(input logic [7:0] b);
        int w = 0;
        while (!bus.tx_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic par, input bit dev_ack,
                        input bit exp_ack, input bit exp_to, input bit clocks);
        int inh = 0;
        int w = 0;
        int base;
        exp_q.push_back('{frame: {1'b1, par, b}, ack: exp_ack, to: exp_to, chk_frame: !exp_to});
        base = done_cnt;
        issue(b);
        while (ps2_clk_oe && !ps2_data_oe && inh < 2 * int'(INH)) begin
            inh++;
            @(negedge clk);
        end
        chk("inhibit_len", inh, INH);
        if (clocks) run_device(dev_ack, 11);
        while (done_cnt == base && w < int'(INH + TMO) + 2000) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", done_cnt - base, 1);
        if (exp_to) begin
            chk("to_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
            chk("to_data_oe", {31'b0, ps2_data_oe}, 32'd0);
            chk("to_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
        end
    endtask

    initial begin
        int base;
        vecs[0] = '{data: 8'hED, par: 1'b1, dev_ack: 1'b1, exp_ack: 1'b1};
        vecs[1] = '{data: 8'h01, par: 1'b0, dev_ack: 1'b1, exp_ack: 1'b1};
        vecs[2] = '{data: 8'h00, par: 1'b1, dev_ack: 1'b1, exp_ack: 1'b1};
        vecs[3] = '{data: 8'hFF, par: 1'b1, dev_ack: 1'b1, exp_ack: 1'b1};
        vecs[4] = '{data: 8'h80, par: 1'b0, dev_ack: 1'b1, exp_ack: 1'b1};
        vecs[5] = '{data: 8'hA5, par: 1'b1, dev_ack: 1'b0, exp_ack: 1'b0};

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_ack_ok", {31'b0, bus.ack_ok}, 32'd0);
        chk("rst_timeout", {31'b0, bus.timeout_err}, 32'd0);
        chk("rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        chk("rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].par, vecs[i].dev_ack, vecs[i].exp_ack, 1'b0, 1'b1);
            repeat (10) @(negedge clk);
        end

        // Requests while busy must be dropped without disturbing the frame in flight.
        fork
            send(8'hED, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            begin
                repeat (50) @(negedge clk);
                for (int p = 0; p < 3; p++) begin
                    chk("busy_tx_ready", {31'b0, bus.tx_ready}, 32'd0);
                    bus.tx_data  = 8'h55;
                    bus.tx_valid = 1'b1;
                    @(negedge clk);
                    bus.tx_valid = 1'b0;
                    repeat (100) @(negedge clk);
                end
            end
        join
        repeat (10) @(negedge clk);

        send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);

        // Reset after the 4th fall: d3 of 0x00 is being driven low.
        base = done_cnt;
        issue(8'h00);
        run_device(1'b0, 4);
        chk("pre_rst_data_oe", {31'b0, ps2_data_oe}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_clk_oe", {31'b0, ps2_clk_oe}, 32'd0);
        chk("mid_rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
        chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("no_done_after_rst", done_cnt - base, 0);
        send(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
